// File: rtl/bcd_split_arbiter_pkg.sv
// Shared constants and state encoding for the BCD split arbiter.
// Both the top and the round-robin sub-module take their sizing from here.
package bcd_split_arbiter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int VALW_DEF = 7;
    localparam int DIVISOR  = 10;
    localparam int MAX_VAL  = 99;
    localparam int REM_W    = 7;
    localparam int CNT_W    = 4;
    localparam int ID_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_split_arbiter_rr_arbiter.sv
// Round-robin grant: scans req starting at ptr and returns the first hit
// as a one-hot grant plus its index.
module rr_arbiter
    import bcd_split_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] idx_o,
    output logic            valid_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_i[(int'(ptr_i) + k) % NREQ]) begin
                found                                   = 1'b1;
                idx_o                                   = ID_W'((int'(ptr_i) + k) % NREQ);
                grant_o[(int'(ptr_i) + k) % NREQ]       = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/bcd_split_arbiter.sv
// Shared binary-to-BCD (tens/ones) converter: one subtract-by-10 datapath
// time-shared among NREQ requesters via round-robin arbitration.
module bcd_split_arbiter
    import bcd_split_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int VALW = VALW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*VALW-1:0] val,
    output logic [NREQ-1:0]      ack,
    output logic [3:0]           tens,
    output logic [3:0]           ones,
    output logic [1:0]           res_id,
    output logic                 err,
    output logic                 busy
);

    state_e            state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [REM_W-1:0]  rem_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_flag_q;
    logic [NREQ-1:0]   ack_q;
    logic [CNT_W-1:0]  tens_q;
    logic [3:0]        ones_q;
    logic [ID_W-1:0]   res_id_q;
    logic              err_q;

    logic [NREQ-1:0]   gnt_oh;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_vld;
    logic [VALW-1:0]   val_sel;
    logic              clamp_d;
    logic [REM_W-1:0]  rem_d;
    logic [ID_W-1:0]   ptr_d;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (gnt_oh),
        .idx_o   (gnt_idx),
        .valid_o (gnt_vld)
    );

    always_comb begin
        val_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) val_sel = val[i*VALW +: VALW];
        end
        clamp_d = (val_sel > VALW'(MAX_VAL));
        rem_d   = clamp_d ? REM_W'(MAX_VAL) : REM_W'(val_sel);
        ptr_d   = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            ack_q      <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            res_id_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        state_q    <= ST_SUB;
                        id_q       <= gnt_idx;
                        ptr_q      <= ptr_d;
                        rem_q      <= rem_d;
                        cnt_q      <= '0;
                        err_flag_q <= clamp_d;
                    end
                end
                ST_SUB: begin
                    if (rem_q >= REM_W'(DIVISOR)) begin
                        rem_q <= rem_q - REM_W'(DIVISOR);
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        // Results land on this edge so they are visible during DONE.
                        state_q  <= ST_DONE;
                        ack_q    <= NREQ'(1) << id_q;
                        tens_q   <= cnt_q;
                        ones_q   <= rem_q[3:0];
                        res_id_q <= id_q;
                        err_q    <= err_flag_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ack    = ack_q;
    assign tens   = tens_q;
    assign ones   = ones_q;
    assign res_id = res_id_q;
    assign err    = err_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bcd_split_arbiter.sv
// Bench for bcd_split_arbiter: directed corner cases plus randomized request
// sets checked against a round-robin / divide-by-10 reference model.
module tb_bcd_split_arbiter;

    localparam int NREQ = 4;
    localparam int VALW = 7;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*VALW-1:0] val;
    logic [NREQ-1:0]      ack;
    logic [3:0]           tens;
    logic [3:0]           ones;
    logic [1:0]           res_id;
    logic                 err;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;
    int last_gnt;
    int exp_tens_hold;
    int exp_ones_hold;

    bcd_split_arbiter #(.NREQ(NREQ), .VALW(VALW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .val    (val),
        .ack    (ack),
        .tens   (tens),
        .ones   (ones),
        .res_id (res_id),
        .err    (err),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int i, input int v);
        val[i*VALW +: VALW] = VALW'(v);
        req[i]              = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic do_job(input bit drop);
        int  n;
        int  lat;
        int  exp_id;
        int  v;
        int  ev;
        int  c;
        bit  found;
        n = 0;
        while (!(busy === 1'b0 && req != '0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_err++;
            $error("FAIL grant_timeout: observed no grant expected grant within 100 cycles");
            return;
        end
        found  = 1'b0;
        exp_id = 0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (last_gnt + k) % NREQ;
            if (!found && req[c]) begin
                found  = 1'b1;
                exp_id = c;
            end
        end
        v        = int'(val[exp_id*VALW +: VALW]);
        ev       = (v > 99) ? 99 : v;
        last_gnt = exp_id;
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
            if (ack == '0) chk("err_outside_done", 32'(err), 32'(0));
        end while (ack == '0 && lat < 30);
        chk("latency", 32'(lat), 32'(ev / 10 + 2));
        chk("ack_onehot", 32'(ack), 32'(1) << exp_id);
        chk("tens", 32'(tens), 32'(ev / 10));
        chk("ones", 32'(ones), 32'(ev % 10));
        chk("res_id", 32'(res_id), 32'(exp_id));
        chk("err", 32'(err), 32'(v > 99));
        exp_tens_hold = ev / 10;
        exp_ones_hold = ev % 10;
        if (drop) req[exp_id] = 1'b0;
        @(negedge clk);
        chk("ack_after_done", 32'(ack), 32'(0));
        chk("err_after_done", 32'(err), 32'(0));
        chk("tens_hold", 32'(tens), 32'(exp_tens_hold));
        chk("ones_hold", 32'(ones), 32'(exp_ones_hold));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        val   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_tens", 32'(tens), 32'(0));
        chk("rst_ones", 32'(ones), 32'(0));
        chk("rst_res_id", 32'(res_id), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        rst_n    = 1'b1;
        last_gnt = NREQ - 1;
        @(negedge clk);

        // Fairness: all four held high, expected order 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) post(i, int'($urandom_range(0, 127)));
        for (int k = 0; k < 5; k++) begin
            do_job(1'b0);
            chk("fair_order", 32'(res_id), 32'(k % NREQ));
        end
        req = '0;
        @(negedge clk);

        post(0, 47);  do_job(1'b1);
        post(0, 0);   do_job(1'b1);
        post(3, 99);  do_job(1'b1);
        post(2, 10);  do_job(1'b1);
        post(2, 120); do_job(1'b1);

        // Reset in the middle of a job: aborted, then restarted from scratch.
        post(0, 80);
        repeat (4) begin
            @(negedge clk);
            chk("pre_reset_no_ack", 32'(ack), 32'(0));
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack), 32'(0));
        chk("midrst_tens", 32'(tens), 32'(0));
        chk("midrst_ones", 32'(ones), 32'(0));
        chk("midrst_res_id", 32'(res_id), 32'(0));
        chk("midrst_err", 32'(err), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        last_gnt = NREQ - 1;
        do_job(1'b1);

        for (int r = 0; r < 25; r++) begin
            int mask;
            mask = int'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (mask[i]) post(i, int'($urandom_range(0, 127)));
            end
            for (int j = 0; j < NREQ && req != '0; j++) do_job(1'b1);
            chk("rand_all_served", 32'(req), 32'(0));
        end

        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_tens_hold", 32'(tens), 32'(exp_tens_hold));
        chk("idle_ones_hold", 32'(ones), 32'(exp_ones_hold));
        chk("idle_ack", 32'(ack), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
